clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Multi-channel programmable clock-enable divider; successor to the fixed ripple divide-by-2/4/8/16 chain.
- Every channel runs synchronously on `clk`; no derived clocks. Each channel produces a divided square wave plus a one-cycle terminal tick.
- Divide ratio and enable are per-channel and runtime-writable; ratio changes are glitch-free.
- A masked AND of channel outputs provides the legacy combined `y` output for the TinyTapeout top level.

Parameters:
- NUM_CH, 4, number of divider channels (1..8).
- CNT_W, 8, counter and ratio width in bits; must be >= NUM_CH+1.
- RESET_EN, 1, channel enable value after reset (1 = all channels run out of reset).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cfg_we  input  1  config write strobe, one cycle.
- cfg_ch  input  $clog2(NUM_CH) (min 1)  channel addressed by the write.
- cfg_div  input  CNT_W  new divide ratio R.
- cfg_en  input  1  new channel enable.
- and_mask  input  NUM_CH  channels included in `y`.
- div_out  output  NUM_CH  divided square wave per channel, registered.
- tick  output  NUM_CH  one-cycle pulse on the last cycle of each period, registered.
- y  output  1  AND of `div_out` over `and_mask`; 0 if the mask is zero.
- sync  input  1  present only with CLK_DIV_SYNC_EN.

Behaviour:
- Reset is asynchronous. It sets:
  - cnt = 0, div_out = 0, tick = 0, pending-valid = 0;
  - en[i] = RESET_EN;
  - R_cur[i] = 2^(i+1), saturated to 2^CNT_W-1. At reset this reproduces /2, /4, /8, /16.
- Effective ratio: Reff = max(R, 2). Written values 0 and 1 are stored but behave as 2.
- Enabled channel counting:
  - cnt runs 0..Reff-1, then wraps to 0.
  - div_out = 1 while cnt < ceil(Reff/2), else 0. Examples: R=4 gives 1100, R=3 gives 110, R=2 gives 10.
- Output timing:
  - div_out and tick are registered and aligned to cnt (no extra latency).
  - The first enabled cycle after reset or enable has cnt = 0 and div_out = 1.
  - tick = 1 exactly when cnt == Reff-1.
- Disabled channel: cnt held at 0, div_out = 0, tick = 0.
- Write to an enabled channel with cfg_en = 1:
  - cfg_div goes to the pending register; pending-valid is set.
  - At the next terminal cycle, R_cur takes the pending value and pending-valid clears. cnt wraps to 0 under the new ratio, so no truncated or stretched period is emitted.
- Write with cfg_en = 1 to a disabled channel: R_cur is loaded immediately; counting starts from cnt = 0 on the next cycle.
- Write with cfg_en = 0: the channel stops on the next cycle (cnt = 0, outputs 0). R_cur is loaded immediately and any pending value is discarded.
- Write in the same cycle as that channel's terminal count: the written value takes effect at that wrap and no pending entry remains.
- Multiple writes before a terminal count: the last write wins.
- Write with cfg_ch >= NUM_CH: ignored.
- `y` is combinational from the registered div_out and and_mask. It does not depend on cfg inputs.
- Reset asserted mid-period: immediate clear; no partial tick.

Optional Feature:
- Macro: CLK_DIV_SYNC_EN.
- Defined:
  - Adds the `sync` input.
  - sync = 1 forces every enabled channel's cnt to 0 on the next cycle and applies any pending ratio. This phase-aligns all channels.
  - Priority: reset > sync > cfg write > terminal wrap.
- Undefined: no `sync` port; channels only align through reset or enable.

Decomposition:
- Package clk_div_pkg:
  - CNT_W default constant;
  - clog2 helper function;
  - reset-ratio function (2^(i+1), saturated);
  - Reff helper.
- Sub-module clk_div_chan holds one channel (cnt, R_cur, pending, en, outputs). clk_div_prog instantiates NUM_CH copies via generate and adds config decode and the `y` AND tree.

Test Plan:
- Reset release, default params: div_out[0..3] show periods 2/4/8/16 with 50% duty. y = div_out[0] & div_out[2] when and_mask = 4'b0101; tick[3] pulses every 16 clocks.
- Write ch1 R=3 mid-period of the /4 pattern: current 1100 period completes, then 110 repeats. No short or long period; tick[1] spacing is 4 then 3.
- Write ch0 R=0, then R=1: both behave as /2 (10 pattern).
- Write ch2 cfg_en=0: next cycle div_out[2]=0, tick[2]=0. Re-enable with R=5: next cycle div_out=1; pattern 11100.
- Two writes (R=6, then R=7) before ch3's terminal: only R=7 is applied. Separately, a write coincident with the terminal cycle takes effect at that wrap. Reset mid-period clears all outputs asynchronously.
- With CLK_DIV_SYNC_EN, channels running R=3 and R=4: a sync pulse gives all cnt = 0 next cycle, all div_out = 1, and ticks aligned at cycle 12.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the programmable clock-enable divider
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;

    // Select width for a channel index; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Power-on ratio of channel i: 2^(i+1), clipped to the largest w-bit value.
    function automatic int reset_ratio(input int i, input int w);
        return (i + 1 >= w) ? (1 << w) - 1 : 1 << (i + 1);
    endfunction

    // Ratios 0 and 1 are stored as written but run as /2.
    function automatic int reff(input int r);
        return (r < 2) ? 2 : r;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: configuration and output bundle of clk_div_prog
//   master drives cfg_we/cfg_ch/cfg_div/cfg_en/and_mask and observes div_out/tick/y;
//   slave is the divider side of the same signals.
interface clk_div_prog_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = clk_div_pkg::CNT_W_DEF
) ();
    localparam int CH_W = clk_div_pkg::clog2_min1(NUM_CH);
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_en;
    logic [NUM_CH-1:0] and_mask;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] tick;
    logic              y;
    modport master (output cfg_we, cfg_ch, cfg_div, cfg_en, and_mask, input div_out, tick, y);
    modport slave  (input cfg_we, cfg_ch, cfg_div, cfg_en, and_mask, output div_out, tick, y);
endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel (counter, live and pending ratio, enable, registered outputs)
//   clk, reset (async, active-high); sync forces a phase realign; we/cfg_div/cfg_en are the
//   decoded write for this channel; div_out is the square wave, tick marks the last period cycle.
module clk_div_chan import clk_div_pkg::*; #(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] R_INIT   = CNT_W'(2),
    parameter bit               RESET_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync,
    input  logic             we,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
    output logic             div_out,
    output logic             tick
);
    logic [CNT_W-1:0] cnt, r_cur, pend, cnt_n, r_n, pend_n, re_cur, re_n;
    logic [CNT_W:0]   half_n;
    logic             en, run, pend_v, en_n, pend_v_n, wrap, ld_now;

    // run marks that the counter produced output last cycle; it is clear after reset
    // and while disabled so the first active cycle always starts at cnt = 0.
    always_comb begin
        re_cur   = CNT_W'(reff(int'(r_cur)));
        wrap     = run && (sync || cnt == re_cur - CNT_W'(1));
        en_n     = we ? cfg_en : en;
        ld_now   = we && (!cfg_en || !run || wrap);
        r_n      = ld_now ? cfg_div : (wrap && pend_v) ? pend : r_cur;
        pend_n   = (we && !ld_now) ? cfg_div : pend;
        pend_v_n = we ? !ld_now : (pend_v && !wrap);
        cnt_n    = (!en_n || !run || wrap) ? '0 : cnt + CNT_W'(1);
        re_n     = CNT_W'(reff(int'(r_n)));
        half_n   = ({1'b0, re_n} + (CNT_W+1)'(1)) >> 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            r_cur   <= R_INIT;
            pend    <= '0;
            pend_v  <= 1'b0;
            en      <= RESET_EN;
            run     <= 1'b0;
            div_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            r_cur   <= r_n;
            pend    <= pend_n;
            pend_v  <= pend_v_n;
            en      <= en_n;
            run     <= en_n;
            div_out <= en_n && ({1'b0, cnt_n} < half_n);
            tick    <= en_n && (cnt_n == re_n - CNT_W'(1));
        end
    end
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock-enable divider with masked AND output y
//   clk, reset (async, active-high); bus (slave) carries the config write, and_mask,
//   div_out, tick and y. Defining CLK_DIV_SYNC_EN adds the sync input that realigns
//   every enabled channel to cnt = 0 and applies pending ratios.
module clk_div_prog import clk_div_pkg::*; #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = CNT_W_DEF,
    parameter bit RESET_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
`ifdef CLK_DIV_SYNC_EN
    input  logic          sync,
`endif
    clk_div_prog_if.slave bus
);
    logic sync_i;

`ifdef CLK_DIV_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    // Addresses >= NUM_CH match no channel and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .R_INIT  (CNT_W'(reset_ratio(i, CNT_W))),
            .RESET_EN(RESET_EN)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .sync   (sync_i),
            .we     (bus.cfg_we && int'(bus.cfg_ch) == i),
            .cfg_div(bus.cfg_div),
            .cfg_en (bus.cfg_en),
            .div_out(bus.div_out[i]),
            .tick   (bus.tick[i])
        );
    end

    // Unmasked channels read as 1 so they drop out of the AND; an empty mask gives 0.
    assign bus.y = (|bus.and_mask) && (&(bus.div_out | ~bus.and_mask));
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed scoreboard bench for clk_div_prog
module tb_clk_div_prog;

    typedef struct {
        int         cyc;
        string      nm;
        int         ch;
        logic [3:0] d;
        logic [3:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sync = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    clk_div_prog_if #(.NUM_CH(4), .CNT_W(8)) bus ();

    clk_div_prog #(.NUM_CH(4), .CNT_W(8), .RESET_EN(1'b1)) dut (
        .clk  (clk),
        .reset(reset),
`ifdef CLK_DIV_SYNC_EN
        .sync (sync),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ch 0..3: one channel's div/tick; ch 4: y; ch 5: whole div_out/tick vectors.
    always @(negedge clk) begin
        int i;
        exp_t e;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc > cyc) i++;
            else begin
                e = sb[i];
                sb.delete(i);
                n_cmp++;
                if (e.cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s stale expectation for cycle %0d at cycle %0d", e.nm, e.cyc, cyc);
                end else if (e.ch < 4) begin
                    if ({bus.div_out[e.ch], bus.tick[e.ch]} !== {e.d[0], e.t[0]}) begin
                        n_bad++;
                        $display("FAIL %s cyc %0d ch%0d got div=%b tick=%b want div=%b tick=%b",
                                 e.nm, cyc, e.ch, bus.div_out[e.ch], bus.tick[e.ch], e.d[0], e.t[0]);
                    end
                end else if (e.ch == 4) begin
                    if (bus.y !== e.d[0]) begin
                        n_bad++;
                        $display("FAIL %s cyc %0d got y=%b want y=%b", e.nm, cyc, bus.y, e.d[0]);
                    end
                end else if ({bus.div_out, bus.tick} !== {e.d, e.t}) begin
                    n_bad++;
                    $display("FAIL %s cyc %0d got div_out=%b tick=%b want div_out=%b tick=%b",
                             e.nm, cyc, bus.div_out, bus.tick, e.d, e.t);
                end
            end
        end
    end

    task automatic push_pat(input string nm, input int ch, input int c0, input string d, input string t);
        for (int k = 0; k < d.len(); k++)
            sb.push_back('{c0 + k, nm, ch, {3'b0, d[k] == "1"}, {3'b0, t.len() > k && t[k] == "1"}});
    endtask

    task automatic push_vec(input string nm, input int c, input logic [3:0] d, input logic [3:0] t);
        sb.push_back('{c, nm, 5, d, t});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int ch, input int dv, input bit en);
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = 2'(ch);
        bus.cfg_div = 8'(dv);
        bus.cfg_en  = en;
        step(1);
        bus.cfg_we  = 1'b0;
    endtask

    task automatic do_reset(output int rc);
        step(1);
        reset = 1'b1;
        push_vec("rst_async", cyc, 4'b0000, 4'b0000);
        step(1);
        reset = 1'b0;
        rc = cyc;
        push_vec("rst_hold", rc, 4'b0000, 4'b0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_div  = '0;
        bus.cfg_en   = 1'b0;
        bus.and_mask = 4'b0101;

        do_reset(rc);
        push_pat("rst_ch0", 0, rc + 1, "1010101010101010", "0101010101010101");
        push_pat("rst_ch1", 1, rc + 1, "1100110011001100", "0001000100010001");
        push_pat("rst_ch2", 2, rc + 1, "1111000011110000", "0000000100000001");
        push_pat("rst_ch3", 3, rc + 1, "11111111000000001111111100000000",
                                       "00000000000000010000000000000001");
        push_pat("rst_y", 4, rc + 1, "1010000010100000", "");
        step(33);

        do_reset(rc);
        bus.and_mask = 4'b0000;
        push_pat("y_nomask", 4, rc + 1, "0000", "");
        push_pat("ch1_r3", 1, rc + 1, "1100110110110", "0001001001001");
        step(2);
        cfg_write(1, 3, 1'b1);
        step(12);
        bus.and_mask = 4'b0101;

        do_reset(rc);
        push_pat("ch0_r0_r1", 0, rc + 1, "10101010101010", "01010101010101");
        step(1);
        cfg_write(0, 0, 1'b1);
        step(2);
        cfg_write(0, 1, 1'b1);
        step(11);

        do_reset(rc);
        push_pat("ch2_dis_en", 2, rc + 1, "110001110011100", "000000000100001");
        step(2);
        cfg_write(2, 8, 1'b0);
        step(2);
        cfg_write(2, 5, 1'b1);
        step(12);

        do_reset(rc);
        push_pat("ch3_last_wins", 3, rc + 1, "111111110000000011110001111000",
                                             "000000000000000100000010000001");
        push_pat("ch1_at_term", 1, rc + 1, "1100101010", "0001010101");
        step(2);
        cfg_write(3, 6, 1'b1);
        cfg_write(3, 7, 1'b1);
        cfg_write(1, 2, 1'b1);
        step(27);

`ifdef CLK_DIV_SYNC_EN
        do_reset(rc);
        cfg_write(0, 3, 1'b1);
        step(4);
        push_vec("sync_all", rc + 6, 4'b1111, 4'b0000);
        push_pat("sync_ch0", 0, rc + 6, "110110110110", "001001001001");
        push_pat("sync_ch1", 1, rc + 6, "110011001100", "000100010001");
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        step(13);
`endif

        do_reset(rc);
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
